// File: rtl/game_pkg.sv
// Shared round-control definitions: FSM states, advantage/winner codes,
// default frame counts and the frame-count clamp used by the round timers.
package game_pkg;

  typedef enum logic [2:0] {
    ST_PLAY    = 3'd0,
    ST_DYING   = 3'd1,
    ST_RESPAWN = 3'd2,
    ST_KNOCK   = 3'd3,
    ST_SHIFT   = 3'd4,
    ST_OVER    = 3'd5
  } state_t;

  localparam logic [1:0] ADV_NONE  = 2'b00;
  localparam logic [1:0] ADV_LEFT  = 2'b01;
  localparam logic [1:0] ADV_RIGHT = 2'b10;

  localparam logic [1:0] WIN_NONE  = 2'b00;
  localparam logic [1:0] WIN_LEFT  = 2'b01;
  localparam logic [1:0] WIN_RIGHT = 2'b10;

  localparam int DEF_DEATH_FRAMES = 60;
  localparam int DEF_KNOCK_FRAMES = 8;
  localparam int DEF_SHIFT_FRAMES = 30;
  localparam int DEF_WIN_BOARD    = 3;

  // Bit positions of the event inputs in the edge-detector vector
  localparam int EV_DEAD_L    = 0;
  localparam int EV_DEAD_R    = 1;
  localparam int EV_COLLISION = 2;
  localparam int EV_POS_RESET = 3;

  // A zero frame count still holds the state for one tick; counts saturate at 8 bits
  function automatic logic [7:0] frames_to_count(input int frames);
    if (frames <= 0)
      return 8'd1;
    else if (frames > 255)
      return 8'd255;
    else
      return frames[7:0];
  endfunction

endpackage

// File: rtl/round_control_if.sv
// Event and status bundle between the hit-detection/player logic (master)
// and the round controller (slave).
interface round_control_if;
  import game_pkg::*;

  logic              tick;
  logic              dead_L;
  logic              dead_R;
  logic              collision;
  logic              pos_reset;
  logic signed [2:0] board_controller;

  logic              freeze;
  logic              knockback;
  logic              respawn_L;
  logic              respawn_R;
  logic              screen_shift;
  logic [1:0]        advantage;
  logic              game_over;
  logic [1:0]        winner;

  modport master (
    output tick, dead_L, dead_R, collision, pos_reset, board_controller,
    input  freeze, knockback, respawn_L, respawn_R, screen_shift,
           advantage, game_over, winner
  );

  modport slave (
    input  tick, dead_L, dead_R, collision, pos_reset, board_controller,
    output freeze, knockback, respawn_L, respawn_R, screen_shift,
           advantage, game_over, winner
  );
endinterface

// File: rtl/edge_detect.sv
// Registered rising-edge detector: samples the levels every cycle and flags
// a rise only from registered copies, so the pulse is glitch-free.
module edge_detect #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] i_level,
  output logic [WIDTH-1:0] o_rise
);
  logic [WIDTH-1:0] r_sample;
  logic [WIDTH-1:0] r_prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sample <= '0;
      r_prev   <= '0;
    end else begin
      r_sample <= i_level;
      r_prev   <= r_sample;
    end
  end

  assign o_rise = r_sample & ~r_prev;
endmodule

// File: rtl/round_control.sv
// Round sequencing for the duel: kills, respawns, sword-clash knockback,
// board shifts and match end, all timed in video-frame ticks.
module round_control
  import game_pkg::*;
#(
  parameter int DEATH_FRAMES = DEF_DEATH_FRAMES,
  parameter int KNOCK_FRAMES = DEF_KNOCK_FRAMES,
  parameter int SHIFT_FRAMES = DEF_SHIFT_FRAMES,
  parameter int WIN_BOARD    = DEF_WIN_BOARD
) (
  input logic            clk,
  input logic            reset_n,
  round_control_if.slave bus
);
  localparam logic [7:0]        LP_DEATH   = frames_to_count(DEATH_FRAMES);
  localparam logic [7:0]        LP_KNOCK   = frames_to_count(KNOCK_FRAMES);
  localparam logic [7:0]        LP_SHIFT   = frames_to_count(SHIFT_FRAMES);
  localparam logic signed [2:0] LP_WIN_POS = 3'(WIN_BOARD);
  localparam logic signed [2:0] LP_WIN_NEG = 3'(-WIN_BOARD);

  logic [3:0] w_rise;
  logic       w_win_l;
  logic       w_win_r;
  logic       w_dead_any;

  state_t     r_state;
  logic [7:0] r_cnt;
  logic       r_mark_l;
  logic       r_mark_r;
  logic       r_freeze;
  logic       r_knock;
  logic       r_resp_l;
  logic       r_resp_r;
  logic       r_shift;
  logic [1:0] r_adv;
  logic       r_over;
  logic [1:0] r_winner;

  edge_detect #(.WIDTH(4)) u_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .i_level ({bus.pos_reset, bus.collision, bus.dead_R, bus.dead_L}),
    .o_rise  (w_rise)
  );

  assign w_win_l    = (bus.board_controller == LP_WIN_POS);
  assign w_win_r    = (bus.board_controller == LP_WIN_NEG);
  assign w_dead_any = w_rise[EV_DEAD_L] | w_rise[EV_DEAD_R];

  // Timers are loaded on state entry and only look at tick from the next cycle on
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_PLAY;
      r_cnt    <= '0;
      r_mark_l <= 1'b0;
      r_mark_r <= 1'b0;
      r_freeze <= 1'b0;
      r_knock  <= 1'b0;
      r_resp_l <= 1'b0;
      r_resp_r <= 1'b0;
      r_shift  <= 1'b0;
      r_adv    <= ADV_NONE;
      r_over   <= 1'b0;
      r_winner <= WIN_NONE;
    end else begin
      r_resp_l <= 1'b0;
      r_resp_r <= 1'b0;
      r_shift  <= 1'b0;
      case (r_state)
        ST_PLAY: begin
          if (w_win_l || w_win_r) begin
            r_state  <= ST_OVER;
            r_freeze <= 1'b1;
            r_over   <= 1'b1;
            r_winner <= w_win_l ? WIN_LEFT : WIN_RIGHT;
          end else if (w_rise[EV_POS_RESET]) begin
            r_state  <= ST_SHIFT;
            r_cnt    <= LP_SHIFT;
            r_freeze <= 1'b1;
            r_shift  <= 1'b1;
          end else if (w_dead_any) begin
            r_state  <= ST_DYING;
            r_cnt    <= LP_DEATH;
            r_freeze <= 1'b1;
            r_mark_l <= w_rise[EV_DEAD_L];
            r_mark_r <= w_rise[EV_DEAD_R];
            // The survivor gains the right to advance; a double kill gives nobody the edge
            case ({w_rise[EV_DEAD_L], w_rise[EV_DEAD_R]})
              2'b10:   r_adv <= ADV_RIGHT;
              2'b01:   r_adv <= ADV_LEFT;
              default: r_adv <= ADV_NONE;
            endcase
          end else if (w_rise[EV_COLLISION]) begin
            r_state <= ST_KNOCK;
            r_cnt   <= LP_KNOCK;
            r_knock <= 1'b1;
          end
        end

        ST_DYING: begin
          if (bus.tick) begin
            if (r_cnt == 8'd1) begin
              r_state  <= ST_RESPAWN;
              r_cnt    <= '0;
              r_freeze <= 1'b0;
              r_resp_l <= r_mark_l;
              r_resp_r <= r_mark_r;
            end else begin
              r_cnt <= r_cnt - 8'd1;
            end
          end
        end

        ST_RESPAWN: begin
          r_mark_l <= 1'b0;
          r_mark_r <= 1'b0;
          r_state  <= ST_PLAY;
        end

        ST_KNOCK: begin
          if (bus.tick) begin
            if (r_cnt == 8'd1) begin
              r_state <= ST_PLAY;
              r_cnt   <= '0;
              r_knock <= 1'b0;
            end else begin
              r_cnt <= r_cnt - 8'd1;
            end
          end
        end

        ST_SHIFT: begin
          if (w_win_l || w_win_r) begin
            r_state  <= ST_OVER;
            r_cnt    <= '0;
            r_over   <= 1'b1;
            r_winner <= w_win_l ? WIN_LEFT : WIN_RIGHT;
          end else if (bus.tick) begin
            if (r_cnt == 8'd1) begin
              r_state  <= ST_RESPAWN;
              r_cnt    <= '0;
              r_freeze <= 1'b0;
              r_mark_l <= 1'b1;
              r_mark_r <= 1'b1;
              r_resp_l <= 1'b1;
              r_resp_r <= 1'b1;
            end else begin
              r_cnt <= r_cnt - 8'd1;
            end
          end
        end

        ST_OVER: begin
          r_state <= ST_OVER;
        end

        default: begin
          r_state <= ST_PLAY;
        end
      endcase
    end
  end

  assign bus.freeze       = r_freeze;
  assign bus.knockback    = r_knock;
  assign bus.respawn_L    = r_resp_l;
  assign bus.respawn_R    = r_resp_r;
  assign bus.screen_shift = r_shift;
  assign bus.advantage    = r_adv;
  assign bus.game_over    = r_over;
  assign bus.winner       = r_winner;
endmodule
